// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers: results are computed at the start edge,
// then held in pending registers and committed to HI/LO after a fixed latency.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 5) ? $clog2(MAX_CYC + 1) : 5;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } op_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_phi, w_phi_nxt;
    logic [31:0]      r_plo, w_plo_nxt;
    logic             r_pwr, w_pwr_nxt;

    logic [63:0] w_smul, w_umul;
    logic [31:0] w_abs_a, w_abs_b, w_sdvsr, w_squo_m, w_srem_m, w_squo, w_srem;
    logic [31:0] w_udvsr, w_uquo, w_urem;
    logic [31:0] w_out;

    // Sign-extended unsigned multiply yields the exact signed 64-bit product.
    assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_umul = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes; 0x80000000/-1 wraps back to 0x80000000.
    assign w_abs_a  = a[31] ? -a : a;
    assign w_abs_b  = b[31] ? -b : b;
    assign w_sdvsr  = (w_abs_b == '0) ? 32'd1 : w_abs_b;
    assign w_squo_m = w_abs_a / w_sdvsr;
    assign w_srem_m = w_abs_a % w_sdvsr;
    assign w_squo   = (a[31] ^ b[31]) ? -w_squo_m : w_squo_m;
    assign w_srem   = a[31] ? -w_srem_m : w_srem_m;

    assign w_udvsr = (b == '0) ? 32'd1 : b;
    assign w_uquo  = a / w_udvsr;
    assign w_urem  = a % w_udvsr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_pwr_nxt   = r_pwr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            {w_phi_nxt, w_plo_nxt} = (mdu_op == OP_MULT) ? w_smul : w_umul;
                            w_pwr_nxt   = 1'b1;
                            w_cnt_nxt   = MULT_LOAD;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_phi_nxt   = (mdu_op == OP_DIV) ? w_srem : w_urem;
                            w_plo_nxt   = (mdu_op == OP_DIV) ? w_squo : w_uquo;
                            w_pwr_nxt   = (b != '0);
                            w_cnt_nxt   = DIV_LOAD;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = a;
                        OP_MTLO: w_lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                    if (r_pwr) begin
                        w_hi_nxt = r_phi;
                        w_lo_nxt = r_plo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_pwr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_pwr   <= w_pwr_nxt;
        end
    end

    always_comb begin
        w_out = '0;
        case (mdu_op)
            OP_MFHI: w_out = r_hi;
            OP_MFLO: w_out = r_lo;
            default: ;
        endcase
    end

    assign mdu_out = w_out;
    assign busy    = r_busy;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus random op streams
// compared against a transaction-level arithmetic model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  mdu_op;
    logic        start;
    logic        busy;
    logic [31:0] mdu_out, hi, lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .mdu_op  (mdu_op),
        .start   (start),
        .busy    (busy),
        .mdu_out (mdu_out),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural HI/LO plus the outstanding operation.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_pwr = 1'b0;
    int          m_left = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 1'b0; m_left = 0;
    endtask

    task automatic model_edge(input logic [3:0] op, input logic st, input logic [31:0] ia, input logic [31:0] ib);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] pu;
        sa = ia;
        sb = ib;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            case (op)
                4'd1: begin
                    p = longint'(sa) * longint'(sb);
                    {m_phi, m_plo} = p;
                    m_pwr = 1'b1; m_left = MC;
                end
                4'd2: begin
                    pu = {32'b0, ia} * {32'b0, ib};
                    {m_phi, m_plo} = pu;
                    m_pwr = 1'b1; m_left = MC;
                end
                4'd3: begin
                    m_left = DC;
                    m_pwr  = (ib != 0);
                    if (ib != 0) begin
                        q = longint'(sa) / longint'(sb);
                        r = longint'(sa) % longint'(sb);
                        m_plo = q[31:0];
                        m_phi = r[31:0];
                    end
                end
                4'd4: begin
                    m_left = DC;
                    m_pwr  = (ib != 0);
                    if (ib != 0) begin
                        m_plo = ia / ib;
                        m_phi = ia % ib;
                    end
                end
                4'd5: m_hi = ia;
                4'd6: m_lo = ia;
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, check the combinational read, then check state after the edge.
    task automatic step(input logic [3:0] op, input logic st, input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] exp_out;
        @(negedge clk);
        mdu_op = op; start = st; a = ia; b = ib;
        #1;
        exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check_eq("mdu_out", 64'(mdu_out), 64'(exp_out));
        @(posedge clk);
        model_edge(op, st, ia, ib);
        #1;
        check_eq("busy", 64'(busy), 64'(m_left > 0));
        check_eq("hi", 64'(hi), 64'(m_hi));
        check_eq("lo", 64'(lo), 64'(m_lo));
    endtask

    // Start an op and idle until busy drops; returns the number of cycles busy was seen high.
    task automatic run_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib, output int nbusy);
        nbusy = 0;
        step(op, 1'b1, ia, ib);
        if (busy) nbusy++;
        for (int i = 0; i < 40 && busy; i++) begin
            step(4'd0, 1'b0, $urandom, $urandom);
            if (busy) nbusy++;
        end
        if (busy) check_eq("busy_timeout", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        reset = 1'b0; a = '0; b = '0; mdu_op = '0; start = 1'b0;
        #3;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_hi", 64'(hi), 64'd0);
        check_eq("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First edge after reset release accepts a mult.
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, nb);
        check_eq("mult_busy_cycles", 64'(nb), 64'(MC));
        check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, nb);
        check_eq("multu_hi", 64'(hi), 64'h2);
        check_eq("multu_lo", 64'(lo), 64'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check_eq("div_busy_cycles", 64'(nb), 64'(DC));
        check_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd2, nb);
        check_eq("divu_lo", 64'(lo), 64'd3);
        check_eq("divu_hi", 64'(hi), 64'd1);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check_eq("divovf_lo", 64'(lo), 64'h8000_0000);
        check_eq("divovf_hi", 64'(hi), 64'h0);

        step(4'd5, 1'b1, 32'h11, 32'h0);
        step(4'd6, 1'b1, 32'h22, 32'h0);
        run_op(4'd4, 32'h1234, 32'h0, nb);
        check_eq("div0_busy_cycles", 64'(nb), 64'(DC));
        check_eq("div0_hi", 64'(hi), 64'h11);
        check_eq("div0_lo", 64'(lo), 64'h22);

        // mtlo during RUN ignored; operands changed right after start must not matter.
        step(4'd1, 1'b1, 32'd6, 32'd7);
        step(4'd6, 1'b1, 32'h55, 32'd9);
        for (int i = 0; i < MC; i++) step(4'd8, 1'b0, 32'd100, 32'd100);
        check_eq("overlap_lo", 64'(lo), 64'd42);
        check_eq("overlap_hi", 64'(hi), 64'd0);

        // mthi: HI unchanged before the edge, visible via mfhi next cycle, busy never set.
        @(negedge clk);
        mdu_op = 4'd5; start = 1'b1; a = 32'h1234;
        #1 check_eq("mthi_old_hi", 64'(hi), 64'(m_hi));
        @(posedge clk);
        model_edge(4'd5, 1'b1, 32'h1234, 32'h0);
        #1 check_eq("mthi_busy", 64'(busy), 64'd0);
        step(4'd7, 1'b0, 32'h0, 32'h0);
        check_eq("mfhi_after_mthi", 64'(mdu_out), 64'h1234);

        // Asynchronous reset in the middle of a divide.
        step(4'd3, 1'b1, 32'd1000, 32'd7);
        step(4'd0, 1'b0, 32'd0, 32'd0);
        step(4'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_hi", 64'(hi), 64'd0);
        check_eq("arst_lo", 64'(lo), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DC + 2; i++) step(4'd0, 1'b0, $urandom, $urandom);
        run_op(4'd2, 32'd9, 32'd9, nb);
        check_eq("post_reset_lo", 64'(lo), 64'd81);

        // Random op streams, including starts during RUN and reads of HI/LO.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), pick(), pick());
        end
        for (int i = 0; i < DC + 1; i++) step(4'd0, 1'b0, $urandom, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
